apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//   Responder for the RV32I core data-bus request port (transfer/dataWe/dataAddr/dataWData ->
//   ready/dataRData). Converts each core request into one AMBA APB3 transaction, decodes the
//   address to one of NUM_SLV peripheral selects, and returns the selected slave's read data.
//   Sits between the core and the APB peripherals (RAM, GPIO, UART, timer slots).
// PARAMETERS
//   NUM_SLV     4              number of APB slaves (1..8)
//   BASE_ADDR   32'h1000_0000  base of slave window 0; each slave window is 4 KiB
//   TIMEOUT_CYC 16             ACCESS-state cycle limit (used only with APB_TIMEOUT_EN)
// PORTS
//   clk        in   1            system clock, all state on rising edge
//   reset      in   1            synchronous, active-high reset
//   transfer   in   1            core request strobe, one-cycle pulse per access
//   dataWe     in   1            1 = write, 0 = read; qualified by transfer
//   dataAddr   in   32           byte address; qualified by transfer
//   dataWData  in   32           write data; qualified by transfer
//   dataRData  out  32           read data to core, valid while ready=1
//   ready      out  1            access complete (one cycle)
//   slverr     out  1            completion had error (timeout); 0 when APB_TIMEOUT_EN undefined
//   PADDR      out  32           APB address (registered copy of dataAddr)
//   PWRITE     out  1            APB direction
//   PWDATA     out  32           APB write data
//   PENABLE    out  1            APB enable
//   PSEL       out  NUM_SLV      one-hot slave select
//   PRDATA     in   32*NUM_SLV   slave read data, slave i at [32*i +: 32]
//   PREADY     in   NUM_SLV      slave ready, slave i at bit i
// BEHAVIOUR
//   - Reset: state=IDLE; PADDR, PWDATA, PWRITE, PENABLE, PSEL, ready, slverr, dataRData all 0.
//   - FSM IDLE -> SETUP -> ACCESS -> IDLE.
//     IDLE:   transfer=1 -> latch dataAddr/dataWData/dataWe into PADDR/PWDATA/PWRITE,
//             latch decoded select; go SETUP. transfer=0 -> stay.
//     SETUP:  PSEL = latched select, PENABLE=0; unconditionally go ACCESS.
//     ACCESS: PSEL held, PENABLE=1. Selected PREADY=1 -> ready=1, dataRData=selected PRDATA
//             (combinational this cycle), go IDLE. PREADY=0 -> stay, all APB outputs stable.
//   - Decode: slave i when dataAddr[31:12] == BASE_ADDR[31:12] + i, i < NUM_SLV.
//     Unmapped: PSEL stays all-zero, FSM still walks SETUP/ACCESS; ready=1 in the first
//     ACCESS cycle with dataRData=0; writes dropped.
//   - Latency: transfer in cycle N -> PSEL cycle N+1 -> PENABLE cycle N+2 -> earliest ready N+2.
//   - ready and dataRData nonzero only in the completing ACCESS cycle; dataRData=0 otherwise
//     and on writes.
//   - transfer outside IDLE (including the ready cycle) ignored; no queueing; one outstanding access.
//   - PREADY/PRDATA of unselected slaves ignored.
//   - reset mid-transaction: next cycle IDLE, PSEL/PENABLE=0; slave sees an aborted transfer.
// CONFIGURATION
//   APB_TIMEOUT_EN defined: 5-bit counter cleared on SETUP entry, increments each ACCESS cycle
//     with PREADY=0. At count TIMEOUT_CYC-1 with PREADY still 0: ready=1, slverr=1,
//     dataRData=32'hDEAD_BEEF, go IDLE (drops PSEL/PENABLE next cycle).
//   APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; slverr tied 0.
// TESTING
//   1 write: transfer, addr 0x1000_1004, wdata 0xA5A5_0001, PREADY[1]=1 -> PSEL=4'b0010 at N+1,
//     PENABLE at N+2, PWDATA=0xA5A5_0001, ready=1 at N+2, PSEL=0 at N+3.
//   2 read wait states: addr 0x1000_2000, PREADY[2] low 3 cycles, PRDATA[2]=0x1234_5678 ->
//     ready only at N+5, dataRData=0x1234_5678, PADDR stable N+1..N+5.
//   3 unmapped: addr 0x2000_0000 read -> PSEL=0 throughout, ready=1 at N+2, dataRData=0.
//   4 transfer pulsed at N+1 and N+2 during busy access -> ignored; exactly one APB transaction.
//   5 reset asserted in ACCESS with PREADY=0 -> next cycle PSEL=0, PENABLE=0, ready=0; new
//     transfer afterwards completes normally.
//   6 APB_TIMEOUT_EN, selected PREADY held 0 -> ready=1, slverr=1, dataRData=0xDEAD_BEEF
//     after 16 ACCESS cycles; without macro, still waiting at cycle 100.

Source files
------------

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - core data-bus to APB3 master bridge with one-hot slave decode
// Optional ACCESS-state timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int          NUM_SLV     = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   transfer,
    input  logic                   dataWe,
    input  logic [31:0]            dataAddr,
    input  logic [31:0]            dataWData,
    output logic [31:0]            dataRData,
    output logic                   ready,
    output logic                   slverr,
    output logic [31:0]            PADDR,
    output logic                   PWRITE,
    output logic [31:0]            PWDATA,
    output logic                   PENABLE,
    output logic [NUM_SLV-1:0]     PSEL,
    input  logic [32*NUM_SLV-1:0]  PRDATA,
    input  logic [NUM_SLV-1:0]     PREADY
);

    if (NUM_SLV < 1 || NUM_SLV > 8 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 32) begin : g_param_check
        $error("apb_master_bridge: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t             state, state_nxt;
    logic [NUM_SLV-1:0] sel_q;
    logic [NUM_SLV-1:0] sel_dec;
    logic               sel_pready;
    logic [31:0]        sel_prdata;
    logic               mapped;
    logic               to_hit;

    // Each slave owns one 4 KiB window starting at BASE_ADDR.
    always_comb begin
        sel_dec = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (dataAddr[31:12] == BASE_ADDR[31:12] + 20'(i)) begin
                sel_dec[i] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_pready = 1'b0;
        sel_prdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_q[i]) begin
                sel_pready = sel_pready | PREADY[i];
                sel_prdata = sel_prdata | PRDATA[32*i +: 32];
            end
        end
    end

    assign mapped = |sel_q;

`ifdef APB_TIMEOUT_EN
    logic [4:0] to_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state == S_SETUP) begin
            to_cnt <= '0;
        end else if (state == S_ACCESS && !sel_pready) begin
            to_cnt <= to_cnt + 5'd1;
        end
    end

    assign to_hit = (state == S_ACCESS) && !sel_pready && (to_cnt == 5'(TIMEOUT_CYC - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request is captured only in IDLE; later strobes are dropped, not queued.
    always_ff @(posedge clk) begin
        if (reset) begin
            PADDR  <= '0;
            PWDATA <= '0;
            PWRITE <= 1'b0;
            sel_q  <= '0;
        end else if (state == S_IDLE && transfer) begin
            PADDR  <= dataAddr;
            PWDATA <= dataWData;
            PWRITE <= dataWe;
            sel_q  <= sel_dec;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        slverr    = 1'b0;
        dataRData = '0;
        case (state)
            S_IDLE: begin
                if (transfer) begin
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                // Unmapped addresses complete at once with zero data.
                if (!mapped || sel_pready) begin
                    ready     = 1'b1;
                    state_nxt = S_IDLE;
                    if (mapped && !PWRITE) begin
                        dataRData = sel_prdata;
                    end
                end else if (to_hit) begin
                    ready     = 1'b1;
                    slverr    = 1'b1;
                    dataRData = 32'hDEAD_BEEF;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        PSEL    = (state == S_SETUP || state == S_ACCESS) ? sel_q : '0;
        PENABLE = (state == S_ACCESS);
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - table-driven bench for apb_master_bridge
module tb_apb_master_bridge;

    logic         clk = 1'b0;
    logic         reset;
    logic         transfer;
    logic         dataWe;
    logic [31:0]  dataAddr;
    logic [31:0]  dataWData;
    logic [31:0]  dataRData;
    logic         ready;
    logic         slverr;
    logic [31:0]  PADDR;
    logic         PWRITE;
    logic [31:0]  PWDATA;
    logic         PENABLE;
    logic [3:0]   PSEL;
    logic [127:0] PRDATA;
    logic [3:0]   PREADY;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_master_bridge #(
        .NUM_SLV(4),
        .BASE_ADDR(32'h1000_0000),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .transfer(transfer),
        .dataWe(dataWe),
        .dataAddr(dataAddr),
        .dataWData(dataWData),
        .dataRData(dataRData),
        .ready(ready),
        .slverr(slverr),
        .PADDR(PADDR),
        .PWRITE(PWRITE),
        .PWDATA(PWDATA),
        .PENABLE(PENABLE),
        .PSEL(PSEL),
        .PRDATA(PRDATA),
        .PREADY(PREADY)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wait_n;
        logic [31:0] prdata;
        logic [3:0]  exp_psel;
        logic [31:0] exp_rdata;
        logic        poke;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] addr_seen;
        int          done_cyc;
        int          paddr_bad;
        string       tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        transfer  = 1'b1;
        dataWe    = v.we;
        dataAddr  = v.addr;
        dataWData = v.wdata;
        PREADY    = ~v.exp_psel;
        PRDATA    = {4{32'hBAD0_BAD0}};
        for (int i = 0; i < 4; i++) begin
            if (v.exp_psel[i]) PRDATA[32*i +: 32] = v.prdata;
        end
        @(negedge clk);
        if (v.poke) begin
            transfer = 1'b1;
            dataAddr = 32'h1000_0000;
            dataWe   = ~v.we;
        end else begin
            transfer = 1'b0;
        end
        #1;
        chk({tag, " setup psel"}, 32'(PSEL), 32'(v.exp_psel));
        chk({tag, " setup penable"}, 32'(PENABLE), 32'd0);
        chk({tag, " setup paddr"}, PADDR, v.addr);
        chk({tag, " setup pwrite"}, 32'(PWRITE), 32'(v.we));
        if (v.we) chk({tag, " setup pwdata"}, PWDATA, v.wdata);
        addr_seen = PADDR;
        done_cyc  = -1;
        paddr_bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            PREADY = (c >= v.wait_n) ? 4'hF : ~v.exp_psel;
            #1;
            if (PADDR !== addr_seen || PSEL !== v.exp_psel || PENABLE !== 1'b1) paddr_bad++;
            if (ready) begin
                done_cyc = c;
                break;
            end
        end
        chk({tag, " ready cycle"}, 32'(done_cyc), 32'(v.exp_psel == 4'd0 ? 0 : v.wait_n));
        chk({tag, " apb stable in access"}, 32'(paddr_bad), 32'd0);
        chk({tag, " rdata"}, dataRData, v.exp_rdata);
        chk({tag, " slverr"}, 32'(slverr), 32'd0);
        @(negedge clk);
        transfer = 1'b0;
        PREADY   = 4'h0;
        #1;
        chk({tag, " post psel"}, 32'(PSEL), 32'd0);
        chk({tag, " post ready"}, 32'(ready), 32'd0);
        chk({tag, " post rdata"}, dataRData, 32'd0);
        @(negedge clk);
        #1;
        chk({tag, " idle psel"}, 32'(PSEL), 32'd0);
        chk({tag, " idle penable"}, 32'(PENABLE), 32'd0);
    endtask

    initial begin
        int got;
        vecs[0] = '{we:1'b1, addr:32'h1000_1004, wdata:32'hA5A5_0001, wait_n:0, prdata:32'h5555_AAAA, exp_psel:4'b0010, exp_rdata:32'h0, poke:1'b0};
        vecs[1] = '{we:1'b0, addr:32'h1000_2000, wdata:32'h0, wait_n:3, prdata:32'h1234_5678, exp_psel:4'b0100, exp_rdata:32'h1234_5678, poke:1'b1};
        vecs[2] = '{we:1'b0, addr:32'h2000_0000, wdata:32'h0, wait_n:0, prdata:32'h0, exp_psel:4'b0000, exp_rdata:32'h0, poke:1'b0};
        vecs[3] = '{we:1'b0, addr:32'h1000_0FFC, wdata:32'h0, wait_n:1, prdata:32'hCAFE_0000, exp_psel:4'b0001, exp_rdata:32'hCAFE_0000, poke:1'b0};
        vecs[4] = '{we:1'b0, addr:32'h1000_3ABC, wdata:32'h0, wait_n:0, prdata:32'h8765_4321, exp_psel:4'b1000, exp_rdata:32'h8765_4321, poke:1'b0};
        vecs[5] = '{we:1'b0, addr:32'h1000_4000, wdata:32'h0, wait_n:0, prdata:32'h0, exp_psel:4'b0000, exp_rdata:32'h0, poke:1'b0};
        vecs[6] = '{we:1'b1, addr:32'h0FFF_F000, wdata:32'h1111_2222, wait_n:0, prdata:32'h0, exp_psel:4'b0000, exp_rdata:32'h0, poke:1'b0};
        vecs[7] = '{we:1'b1, addr:32'h1000_0000, wdata:32'h0BAD_F00D, wait_n:2, prdata:32'h7777_7777, exp_psel:4'b0001, exp_rdata:32'h0, poke:1'b0};

        reset     = 1'b1;
        transfer  = 1'b0;
        dataWe    = 1'b0;
        dataAddr  = '0;
        dataWData = '0;
        PRDATA    = '0;
        PREADY    = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset paddr", PADDR, 32'd0);
        chk("reset pwdata", PWDATA, 32'd0);
        chk("reset pwrite", 32'(PWRITE), 32'd0);
        chk("reset penable", 32'(PENABLE), 32'd0);
        chk("reset psel", 32'(PSEL), 32'd0);
        chk("reset ready", 32'(ready), 32'd0);
        chk("reset slverr", 32'(slverr), 32'd0);
        chk("reset rdata", dataRData, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Reset while the slave is stalling in ACCESS.
        @(negedge clk);
        transfer = 1'b1;
        dataWe   = 1'b0;
        dataAddr = 32'h1000_2000;
        PREADY   = 4'h0;
        @(negedge clk);
        transfer = 1'b0;
        @(negedge clk);
        #1;
        chk("abort in access", 32'(PENABLE), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("abort psel", 32'(PSEL), 32'd0);
        chk("abort penable", 32'(PENABLE), 32'd0);
        chk("abort ready", 32'(ready), 32'd0);
        reset = 1'b0;
        run_vec(8, vecs[0]);

        // Selected slave never answers.
        @(negedge clk);
        transfer = 1'b1;
        dataWe   = 1'b0;
        dataAddr = 32'h1000_0000;
        PREADY   = 4'h0;
        PRDATA   = {4{32'h1357_9BDF}};
        @(negedge clk);
        transfer = 1'b0;
        got = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            if (ready) begin
                got = c;
                break;
            end
        end
`ifdef APB_TIMEOUT_EN
        chk("timeout cycle", 32'(got), 32'd15);
        chk("timeout slverr", 32'(slverr), 32'd1);
        chk("timeout rdata", dataRData, 32'hDEAD_BEEF);
        @(negedge clk);
        #1;
        chk("timeout post psel", 32'(PSEL), 32'd0);
        chk("timeout post penable", 32'(PENABLE), 32'd0);
`else
        chk("no timeout ready", 32'(got), 32'hFFFF_FFFF);
        chk("no timeout penable", 32'(PENABLE), 32'd1);
        chk("no timeout psel", 32'(PSEL), 32'd1);
        chk("no timeout slverr", 32'(slverr), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif
        run_vec(9, vecs[3]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
